// File: rtl/multiplier_pkg.sv
// Shared types and constants for the multiplier streaming front end.
package multiplier_pkg;

    // Controller state encoding (2 bits, all four codes used).
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_CLEAR = 2'd3;

    // Default watchdog limit: a WIDTH-bit shift-and-add core needs about
    // WIDTH cycles, so allow a few cycles of slack on top of that.
    function automatic int default_timeout(input int width);
        return width + 4;
    endfunction

endpackage

// File: rtl/multiplier_watchdog.sv
// Cycle counter used to detect a multiplier core that never completes.
// Counts 0..TIMEOUT-1 and saturates there; terminal_o flags the last count.
module multiplier_watchdog #(
    parameter int TIMEOUT = 12
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign terminal_o = (count_q == CW'(TIMEOUT - 1));

    // Next count: clear wins, otherwise advance while enabled, never wrapping.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !terminal_o) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multiplier_frontend.sv
// Streaming valid/ready wrapper around a start/ready shift-and-add multiplier
// core. One operand pair is in flight at a time; after each result (or a
// watchdog abort) the core is cleared with a one-cycle mult_clear_n pulse.
module multiplier_frontend
    import multiplier_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = default_timeout(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_multiplicand,
    input  logic [WIDTH-1:0]   in_multiplier,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    output logic               mult_start,
    input  logic               mult_ready,
    input  logic [2*WIDTH-1:0] mult_product,
    output logic               mult_clear_n,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               err_timeout,
    input  logic               err_clear
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mult_a_q, mult_a_d;
    logic [WIDTH-1:0]   mult_b_q, mult_b_d;
    logic [2*WIDTH-1:0] out_product_q, out_product_d;
    logic               out_valid_q, out_valid_d;
    logic               err_timeout_q, err_timeout_d;
    logic               clear_n_q, clear_n_d;

    logic               wd_clear;
    logic               wd_enable;
    logic               wd_terminal;
    logic               capture;

    multiplier_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_i    (wd_clear),
        .enable_i   (wd_enable),
        .terminal_o (wd_terminal)
    );

    // A finished product can only be taken when the output slot is free or
    // is being drained in this same cycle.
    assign capture = mult_ready && (!out_valid_q || out_ready);

    // Controller, operand/output register and error flag next-state logic.
    always_comb begin
        state_d       = state_q;
        mult_a_d      = mult_a_q;
        mult_b_d      = mult_b_q;
        out_product_d = out_product_q;
        out_valid_d   = out_valid_q;
        err_timeout_d = err_timeout_q;
        wd_clear      = 1'b0;
        wd_enable     = 1'b0;
        in_ready      = 1'b0;
        mult_start    = 1'b0;

        // Drain first; a capture below overrides it with the new product.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear first; a timeout below overrides it (set has priority).
        if (err_clear) begin
            err_timeout_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mult_a_d = in_multiplicand;
                    mult_b_d = in_multiplier;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                mult_start = 1'b1;
                wd_clear   = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (capture) begin
                    out_product_d = mult_product;
                    out_valid_d   = 1'b1;
                    state_d       = ST_CLEAR;
                end else if (mult_ready) begin
                    // Result ready but output stalled: park, watchdog frozen.
                    state_d = ST_WAIT;
                end else if (wd_terminal) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_CLEAR;
                end else begin
                    wd_enable = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear pulse is registered so it is low for exactly the CLEAR cycle.
        clear_n_d = (state_d != ST_CLEAR);
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            mult_a_q      <= '0;
            mult_b_q      <= '0;
            out_product_q <= '0;
            out_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            clear_n_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            mult_a_q      <= mult_a_d;
            mult_b_q      <= mult_b_d;
            out_product_q <= out_product_d;
            out_valid_q   <= out_valid_d;
            err_timeout_q <= err_timeout_d;
            clear_n_q     <= clear_n_d;
        end
    end

    assign mult_a       = mult_a_q;
    assign mult_b       = mult_b_q;
    assign out_product  = out_product_q;
    assign out_valid    = out_valid_q;
    assign err_timeout  = err_timeout_q;
    assign mult_clear_n = clear_n_q;

endmodule

// File: tb/tb_multiplier_frontend.sv
// Directed bench for multiplier_frontend with a behavioural shift-and-add core.
module tb_multiplier_frontend;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 12;

    logic               clock = 1'b0;
    logic               reset_n = 1'b1;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_multiplicand;
    logic [WIDTH-1:0]   in_multiplier;
    logic [WIDTH-1:0]   mult_a;
    logic [WIDTH-1:0]   mult_b;
    logic               mult_start;
    logic               mult_ready;
    logic [2*WIDTH-1:0] mult_product;
    logic               mult_clear_n;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_product;
    logic               err_timeout;
    logic               err_clear;

    int n_checks = 0;
    int n_fails  = 0;

    multiplier_frontend #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_multiplicand (in_multiplicand),
        .in_multiplier   (in_multiplier),
        .mult_a          (mult_a),
        .mult_b          (mult_b),
        .mult_start      (mult_start),
        .mult_ready      (mult_ready),
        .mult_product    (mult_product),
        .mult_clear_n    (mult_clear_n),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_product     (out_product),
        .err_timeout     (err_timeout),
        .err_clear       (err_clear)
    );

    always #5 clock = ~clock;

    // Behavioural shift-and-add core: WIDTH shift cycles after start, then
    // ready held until the core reset (global reset AND clear pulse).
    logic               core_rst_n;
    logic               stub_mode;
    logic               core_busy;
    logic [3:0]         core_cnt;
    logic [2*WIDTH-1:0] core_acc;
    logic [2*WIDTH-1:0] core_mcand;
    logic [WIDTH-1:0]   core_mplier;

    assign core_rst_n   = reset_n & mult_clear_n;
    assign mult_product = core_acc;

    always @(posedge clock or negedge core_rst_n) begin
        if (!core_rst_n) begin
            core_busy   <= 1'b0;
            core_cnt    <= '0;
            core_acc    <= '0;
            core_mcand  <= '0;
            core_mplier <= '0;
            mult_ready  <= 1'b0;
        end else if (mult_start && !core_busy && !mult_ready) begin
            core_busy   <= 1'b1;
            core_cnt    <= '0;
            core_acc    <= '0;
            core_mcand  <= {{WIDTH{1'b0}}, mult_a};
            core_mplier <= mult_b;
        end else if (core_busy) begin
            if (core_mplier[0]) core_acc <= core_acc + core_mcand;
            core_mcand  <= core_mcand << 1;
            core_mplier <= core_mplier >> 1;
            core_cnt    <= core_cnt + 4'd1;
            if (core_cnt == 4'(WIDTH - 1)) begin
                core_busy  <= 1'b0;
                mult_ready <= !stub_mode;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_in_ready(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        check(tag, in_ready, 1);
    endtask

    task automatic wait_out_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        check(tag, out_valid, 1);
    endtask

    // One operation with out_ready=1, checking the handshake cycle by cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int n = 0;
        int starts = 0;
        wait_in_ready("op_idle");
        in_valid = 1'b1;
        in_multiplicand = a;
        in_multiplier = b;
        step();
        in_valid = 1'b0;
        check("op_start_hi", mult_start, 1);
        check("op_mult_a", mult_a, a);
        check("op_mult_b", mult_b, b);
        check("op_in_ready_busy", in_ready, 0);
        step();
        check("op_start_lo", mult_start, 0);
        while (out_valid !== 1'b1 && n < 60) begin
            step();
            if (mult_start) starts++;
            n++;
        end
        check("op_out_valid", out_valid, 1);
        check("op_extra_start", starts, 0);
        check("op_product", out_product, exp);
        check("op_clear_lo", mult_clear_n, 0);
        step();
        check("op_clear_hi", mult_clear_n, 1);
        check("op_in_ready_back", in_ready, 1);
        check("op_drained", out_valid, 0);
        $display("op %0d x %0d -> %0d (expected %0d)", a, b, out_product, exp);
    endtask

    logic [7:0]  bb_a   [4] = '{8'd255, 8'd0,   8'd1, 8'd3};
    logic [7:0]  bb_b   [4] = '{8'd255, 8'd200, 8'd1, 8'd7};
    logic [15:0] bb_exp [4] = '{16'd65025, 16'd0, 16'd1, 16'd21};

    initial begin
        int n;
        int idx;
        int recv;
        logic acc;

        in_valid = 1'b0;
        in_multiplicand = '0;
        in_multiplier = '0;
        out_ready = 1'b1;
        err_clear = 1'b0;
        stub_mode = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_start", mult_start, 0);
        check("rst_clear_n", mult_clear_n, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_product", out_product, 0);
        check("rst_err", err_timeout, 0);
        check("rst_mult_a", mult_a, 0);
        check("rst_mult_b", mult_b, 0);
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Basic operation.
        run_op(8'd13, 8'd11, 16'd143);

        // Back-to-back in_valid held high across four operand pairs.
        idx = 0;
        recv = 0;
        n = 0;
        in_valid = 1'b1;
        in_multiplicand = bb_a[0];
        in_multiplier = bb_b[0];
        while (recv < 4 && n < 300) begin
            acc = in_valid && in_ready;
            step();
            n++;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    in_multiplicand = bb_a[idx];
                    in_multiplier = bb_b[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                check("b2b_product", out_product, bb_exp[recv]);
                $display("b2b result %0d: %0d (expected %0d)", recv, out_product, bb_exp[recv]);
                recv++;
            end
        end
        check("b2b_accepts", idx, 4);
        check("b2b_results", recv, 4);
        n = 0;
        repeat (20) begin
            step();
            if (out_valid === 1'b1) n++;
        end
        check("b2b_no_dup", n, 0);

        // Backpressure: second result parks in WAIT until the slot drains.
        out_ready = 1'b0;
        wait_in_ready("bp_idle1");
        in_valid = 1'b1;
        in_multiplicand = 8'd2;
        in_multiplier = 8'd3;
        step();
        in_valid = 1'b0;
        wait_out_valid("bp_first_valid");
        check("bp_first_product", out_product, 6);
        wait_in_ready("bp_idle2");
        in_valid = 1'b1;
        in_multiplicand = 8'd4;
        in_multiplier = 8'd5;
        step();
        in_valid = 1'b0;
        repeat (50) step();
        check("bp_park_valid", out_valid, 1);
        check("bp_park_product", out_product, 6);
        check("bp_park_err", err_timeout, 0);
        check("bp_park_core_ready", mult_ready, 1);
        check("bp_park_in_ready", in_ready, 0);
        check("bp_park_clear_n", mult_clear_n, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_swap_valid", out_valid, 1);
        check("bp_swap_product", out_product, 20);
        check("bp_swap_clear", mult_clear_n, 0);
        step();
        check("bp_after_in_ready", in_ready, 1);
        step();
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_product", out_product, 20);
        out_ready = 1'b1;
        step();
        check("bp_drain", out_valid, 0);
        $display("backpressure: 6 drained, 20 loaded");

        // Watchdog: stub core never reports ready.
        stub_mode = 1'b1;
        wait_in_ready("to_idle");
        in_valid = 1'b1;
        in_multiplicand = 8'd3;
        in_multiplier = 8'd3;
        step();
        in_valid = 1'b0;
        check("to_start", mult_start, 1);
        step();
        check("to_err_before", err_timeout, 0);
        n = 0;
        while (mult_clear_n === 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("to_wait_cycles", n, TIMEOUT);
        check("to_err_set", err_timeout, 1);
        check("to_no_output", out_valid, 0);
        check("to_clear_lo", mult_clear_n, 0);
        step();
        check("to_clear_hi", mult_clear_n, 1);
        check("to_in_ready", in_ready, 1);
        check("to_err_sticky", err_timeout, 1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("to_err_cleared", err_timeout, 0);
        $display("timeout after %0d wait cycles", n);

        // Second timeout with err_clear in the very cycle the flag is set.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        repeat (TIMEOUT - 1) step();
        check("to2_not_yet", mult_clear_n, 1);
        check("to2_err_not_yet", err_timeout, 0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("to2_set_wins", err_timeout, 1);
        check("to2_clear_lo", mult_clear_n, 0);
        step();
        stub_mode = 1'b0;

        // Asynchronous reset in the middle of WAIT with a pending output.
        out_ready = 1'b0;
        wait_in_ready("rs_idle1");
        in_valid = 1'b1;
        in_multiplicand = 8'd2;
        in_multiplier = 8'd2;
        step();
        in_valid = 1'b0;
        wait_out_valid("rs_first_valid");
        check("rs_first_product", out_product, 4);
        wait_in_ready("rs_idle2");
        in_valid = 1'b1;
        in_multiplicand = 8'd5;
        in_multiplier = 8'd5;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("rs_in_wait", in_ready, 0);
        check("rs_pre_err", err_timeout, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rs_out_valid", out_valid, 0);
        check("rs_clear_n", mult_clear_n, 1);
        check("rs_in_ready", in_ready, 1);
        check("rs_err", err_timeout, 0);
        step();
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        step();
        run_op(8'd7, 8'd9, 16'd63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
